serial_pattern_tx: RTL and testbench



---
 rtl/serial_pattern_tx.sv | 176 +++++++++++++++++
 tb/tb_serial_pattern_tx.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_pattern_tx.sv
// Serial bit-stream transmitter: optional "110" marker, MSB-first payload, idle gap,
// repeated in_rep+1 times per accepted request.
module serial_pattern_tx #(
    parameter int unsigned W    = 8,
    parameter int unsigned LENW = 4,
    parameter int unsigned GAP  = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    in_data,
    input  logic [LENW-1:0] in_len,
    input  logic            in_hdr,
    input  logic [3:0]      in_rep,
    output logic            a,
    output logic            a_valid,
    output logic            busy,
    output logic            frame_done
);

    localparam int unsigned BW = (W > 1) ? $clog2(W) : 1;
    localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [LENW-1:0] WLEN = LENW'(W);
    localparam logic [GW-1:0] GAP_LOAD = (GAP > 0) ? GW'(GAP - 1) : '0;

    typedef enum logic [1:0] {StIdle, StHdr, StData, StGap} state_t;

    state_t          state;
    logic [W-1:0]    data_r;
    logic [LENW-1:0] len_r;
    logic            hdr_r;
    logic [3:0]      rep_r;
    logic [1:0]      hdr_cnt;
    logic [BW-1:0]   bit_cnt;
    logic [GW-1:0]   gap_cnt;

    logic            accept;
    logic [LENW-1:0] len_in;
    logic            src_hdr;
    logic [LENW-1:0] src_len;
    logic [W-1:0]    src_data;
    state_t          start_state;
    logic [BW-1:0]   start_bit;
    logic            data_a;
    logic            start_a;
    logic            start_av;
    logic            frame_end;

    assign in_ready = (state == StIdle) && !reset;
    assign accept   = in_valid && in_ready;
    assign busy     = (state != StIdle);
    assign len_in   = (in_len > WLEN) ? WLEN : in_len;

    // First position of a frame: taken from the inputs on accept, from the latch on restart.
    always_comb begin
        src_hdr  = hdr_r;
        src_len  = len_r;
        src_data = data_r;
        if (state == StIdle) begin
            src_hdr  = in_hdr;
            src_len  = len_in;
            src_data = in_data;
        end
        start_bit   = BW'(src_len - LENW'(1));
        data_a      = src_data[start_bit];
        start_state = StGap;
        start_a     = 1'b0;
        start_av    = 1'b0;
        if (src_hdr) begin
            start_state = StHdr;
            start_a     = 1'b1;
            start_av    = 1'b1;
        end else if (src_len != '0) begin
            start_state = StData;
            start_a     = data_a;
            start_av    = 1'b1;
        end
    end

    always_comb begin
        frame_end = (state == StGap) && (gap_cnt == '0);
        if (GAP == 0) begin
            frame_end = frame_end
                || ((state == StData) && (bit_cnt == '0))
                || ((state == StHdr) && (hdr_cnt == 2'd2) && (len_r == '0));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= StIdle;
            data_r     <= '0;
            len_r      <= '0;
            hdr_r      <= 1'b0;
            rep_r      <= '0;
            hdr_cnt    <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            a          <= 1'b0;
            a_valid    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (frame_end) begin
                if (rep_r != '0) begin
                    rep_r   <= rep_r - 4'd1;
                    state   <= start_state;
                    hdr_cnt <= '0;
                    bit_cnt <= start_bit;
                    gap_cnt <= GAP_LOAD;
                    a       <= start_a;
                    a_valid <= start_av;
                end else begin
                    state      <= StIdle;
                    a          <= 1'b0;
                    a_valid    <= 1'b0;
                    frame_done <= 1'b1;
                end
            end else begin
                case (state)
                    StIdle: begin
                        if (accept) begin
                            data_r  <= in_data;
                            len_r   <= len_in;
                            hdr_r   <= in_hdr;
                            rep_r   <= in_rep;
                            state   <= start_state;
                            hdr_cnt <= '0;
                            bit_cnt <= start_bit;
                            gap_cnt <= GAP_LOAD;
                            a       <= start_a;
                            a_valid <= start_av;
                        end
                    end
                    StHdr: begin
                        if (hdr_cnt != 2'd2) begin
                            hdr_cnt <= hdr_cnt + 2'd1;
                            a       <= (hdr_cnt == 2'd0);
                            a_valid <= 1'b1;
                        end else if (len_r != '0) begin
                            state   <= StData;
                            bit_cnt <= start_bit;
                            a       <= data_a;
                            a_valid <= 1'b1;
                        end else begin
                            state   <= StGap;
                            gap_cnt <= GAP_LOAD;
                            a       <= 1'b0;
                            a_valid <= 1'b0;
                        end
                    end
                    StData: begin
                        if (bit_cnt != '0) begin
                            bit_cnt <= bit_cnt - BW'(1);
                            a       <= data_r[bit_cnt - BW'(1)];
                            a_valid <= 1'b1;
                        end else begin
                            state   <= StGap;
                            gap_cnt <= GAP_LOAD;
                            a       <= 1'b0;
                            a_valid <= 1'b0;
                        end
                    end
                    StGap: begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end
                    default: begin
                        state <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Self-checking bench for serial_pattern_tx against a frame-list reference model.
module tb_serial_pattern_tx;

    localparam int unsigned W    = 8;
    localparam int unsigned LENW = 4;
    localparam int unsigned GAP  = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    in_data;
    logic [LENW-1:0] in_len;
    logic            in_hdr;
    logic [3:0]      in_rep;
    logic            a;
    logic            a_valid;
    logic            busy;
    logic            frame_done;

    int total = 0;
    int bad   = 0;

    // Each entry: {busy, in_ready, frame_done, a_valid, a}
    logic [4:0] exp_q[$];
    logic [4:0] obs_q[$];

    serial_pattern_tx #(.W(W), .LENW(LENW), .GAP(GAP)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_len     (in_len),
        .in_hdr     (in_hdr),
        .in_rep     (in_rep),
        .a          (a),
        .a_valid    (a_valid),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected per-cycle outputs from the cycle after accept through the frame_done cycle.
    function automatic void model(input logic [W-1:0] d, input int l, input bit h, input int r);
        int len;
        len = (l > int'(W)) ? int'(W) : l;
        exp_q.delete();
        for (int k = 0; k <= r; k++) begin
            if (h) begin
                exp_q.push_back(5'b10011);
                exp_q.push_back(5'b10011);
                exp_q.push_back(5'b10010);
            end
            for (int i = len - 1; i >= 0; i--) exp_q.push_back({4'b1001, d[i]});
            for (int g = 0; g < int'(GAP); g++) exp_q.push_back(5'b10000);
            if (!h && len == 0 && GAP == 0) exp_q.push_back(5'b10000);
        end
        exp_q.push_back(5'b01100);
    endfunction

    task automatic do_accept(input logic [W-1:0] d, input logic [LENW-1:0] l, input logic h,
                             input logic [3:0] r, input bit hold);
        int t;
        t = 0;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL accept_wait: in_ready=%b required 1", in_ready);
        end
        in_data  = d;
        in_len   = l;
        in_hdr   = h;
        in_rep   = r;
        in_valid = 1'b1;
        @(negedge clk);
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic capture(input int n);
        obs_q.delete();
        for (int i = 0; i < n; i++) begin
            if (i != 0) @(negedge clk);
            obs_q.push_back({busy, in_ready, frame_done, a_valid, a});
        end
    endtask

    task automatic test_reset;
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = '0;
        in_len   = '0;
        in_hdr   = 1'b0;
        in_rep   = '0;
        repeat (3) @(negedge clk);
        total++;
        if ({busy, in_ready, frame_done, a_valid, a} !== 5'b00000) begin
            bad++;
            $display("FAIL reset_state: got=%b required=00000",
                     {busy, in_ready, frame_done, a_valid, a});
        end
        in_valid = 1'b0;
        reset    = 1'b0;
        @(negedge clk);
        total++;
        if ({busy, in_ready, a_valid} !== 3'b010) begin
            bad++;
            $display("FAIL reset_release: busy/ready/valid=%b required=010",
                     {busy, in_ready, a_valid});
        end
    endtask

    task automatic test_hdr_frame;
        model(8'hA5, 8, 1'b1, 0);
        do_accept(8'hA5, 4'd8, 1'b1, 4'd0, 1'b0);
        capture(exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL hdr_frame cyc=%0d got=%b required=%b", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_late_data;
        model(8'hFE, 3, 1'b0, 0);
        do_accept(8'hFE, 4'd3, 1'b0, 4'd0, 1'b0);
        in_data = 8'h01;
        capture(exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL late_data cyc=%0d got=%b required=%b", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reps;
        int dones;
        model(8'h00, 0, 1'b1, 2);
        do_accept(8'h00, 4'd0, 1'b1, 4'd2, 1'b0);
        capture(16);
        dones = 0;
        for (int i = 0; i < 16; i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL reps cyc=%0d got=%b required=%b", i, obs_q[i], exp_q[i]);
            end
            if (obs_q[i][2]) dones++;
        end
        total++;
        if (dones != 1 || obs_q[15][2] !== 1'b1) begin
            bad++;
            $display("FAIL reps_done: pulses=%0d last=%b required 1 pulse at cycle 16",
                     dones, obs_q[15][2]);
        end
    endtask

    task automatic test_clamp;
        model(8'h81, 12, 1'b0, 0);
        do_accept(8'h81, 4'd12, 1'b0, 4'd0, 1'b1);
        capture(exp_q.size());
        in_valid = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL clamp cyc=%0d got=%b required=%b", i, obs_q[i], exp_q[i]);
            end
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL clamp_idle: busy=%b required 0", busy);
        end
    endtask

    task automatic test_reset_mid;
        logic [W-1:0] d;
        d = W'($urandom);
        do_accept(d, 4'd8, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            if (i != 0) @(negedge clk);
            total++;
            if ({a_valid, a} !== {1'b1, d[W-1-i]}) begin
                bad++;
                $display("FAIL pre_reset bit=%0d got=%b required=%b", i, {a_valid, a},
                         {1'b1, d[W-1-i]});
            end
        end
        reset = 1'b1;
        @(negedge clk);
        total++;
        if ({busy, in_ready, frame_done, a_valid, a} !== 5'b00000) begin
            bad++;
            $display("FAIL mid_reset: got=%b required=00000",
                     {busy, in_ready, frame_done, a_valid, a});
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if ({busy, frame_done} !== 2'b00) begin
                bad++;
                $display("FAIL post_reset cyc=%0d busy/done=%b required=00", i,
                         {busy, frame_done});
            end
        end
        model(8'h06, 3, 1'b0, 0);
        do_accept(8'h06, 4'd3, 1'b0, 4'd0, 1'b0);
        capture(exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL reset_recover cyc=%0d got=%b required=%b", i, obs_q[i],
                         exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        model(8'h3C, 6, 1'b1, 0);
        do_accept(8'h3C, 4'd6, 1'b1, 4'd0, 1'b1);
        capture(exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL b2b_first cyc=%0d got=%b required=%b", i, obs_q[i], exp_q[i]);
            end
        end
        // in_valid still high: second word is taken on the frame_done edge
        in_data = 8'hC9;
        in_len  = 4'd8;
        in_hdr  = 1'b0;
        in_rep  = 4'd1;
        model(8'hC9, 8, 1'b0, 1);
        @(negedge clk);
        in_valid = 1'b0;
        capture(exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL b2b_second cyc=%0d got=%b required=%b", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random;
        logic [W-1:0]    d;
        logic [LENW-1:0] l;
        logic            h;
        logic [3:0]      r;
        for (int n = 0; n < 20; n++) begin
            d = W'($urandom);
            l = LENW'($urandom_range(0, 15));
            h = 1'($urandom_range(0, 1));
            r = 4'($urandom_range(0, 3));
            model(d, int'(l), h, int'(r));
            do_accept(d, l, h, r, 1'b0);
            in_data = W'($urandom);
            in_len  = LENW'($urandom);
            capture(exp_q.size());
            for (int i = 0; i < exp_q.size(); i++) begin
                total++;
                if (obs_q[i] !== exp_q[i]) begin
                    bad++;
                    $display("FAIL random req=%0d d=%h l=%0d h=%0d r=%0d cyc=%0d got=%b required=%b",
                             n, d, l, h, r, i, obs_q[i], exp_q[i]);
                end
            end
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_hdr_frame();
        test_late_data();
        test_reps();
        test_clamp();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
